// File: rtl/mirfak_fetch_unit.sv
// Instruction fetch unit: Wishbone fetch engine, prefetch FIFO and the IF/ID pipeline register.
// Redirects flush everything in flight; bus errors and misaligned targets park the engine until redirected.
module mirfak_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_bj_i,
    input  logic [31:0] pc_except_i,
    input  logic [31:0] pc_xret_i,
    input  logic        pc_bj_sel_i,
    input  logic        pc_except_sel_i,
    input  logic        pc_xret_sel_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_instruction_o,
    output logic        id_if_exception_o,
    output logic [3:0]  id_if_xcause_o,
    output logic        id_bubble_o,
    output logic [31:0] iwbm_addr_o,
    output logic [31:0] iwbm_dat_o,
    output logic [3:0]  iwbm_sel_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    output logic        iwbm_we_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i,
    input  logic        ifid_enable_i,
    input  logic        ifid_clear_i,
    output logic        if_ready_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [31:0]      NOP      = 32'h0000_0013;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RESTART = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    logic [2:0]       state_r, state_s;
    logic [31:0]      fpc_r, fpc_s;
    logic             cyc_r, cyc_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [PTR_W-1:0] wptr_r, rptr_r;

    logic             redirect_s;
    logic [31:0]      target_s;
    logic             push_s, pop_s;
    logic [31:0]      push_ins_s;
    logic             push_err_s, push_mis_s;
    logic [CNT_W-1:0] cnt_after_ack_s;

    logic [31:0]      pc_mem_r  [FIFO_DEPTH];
    logic [31:0]      ins_mem_r [FIFO_DEPTH];
    logic             err_mem_r [FIFO_DEPTH];
    logic             mis_mem_r [FIFO_DEPTH];

    logic [31:0]      id_pc_r, id_pc4_r, id_ins_r;
    logic             id_exc_r, id_bubble_r;
    logic [3:0]       id_xcause_r;

    // Redirect request and target selection, exception first.
    always_comb begin
        redirect_s = pc_except_sel_i | pc_xret_sel_i | pc_bj_sel_i;
        if (pc_except_sel_i) begin
            target_s = pc_except_i;
        end else if (pc_xret_sel_i) begin
            target_s = pc_xret_i;
        end else if (pc_bj_sel_i) begin
            target_s = pc_bj_i;
        end else begin
            target_s = fpc_r;
        end
    end

    // Head consumption by ID; never while ID is being flushed.
    always_comb begin
        pop_s = ifid_enable_i & ~ifid_clear_i & ~redirect_s & (cnt_r != CNT_ZERO);
        if (pop_s) begin
            cnt_after_ack_s = cnt_r;
        end else begin
            cnt_after_ack_s = cnt_r + CNT_ONE;
        end
    end

    // Fetch sequencing: next state, next fetch pointer and what (if anything) enters the FIFO.
    always_comb begin
        state_s    = state_r;
        fpc_s      = fpc_r;
        push_s     = 1'b0;
        push_ins_s = NOP;
        push_err_s = 1'b0;
        push_mis_s = 1'b0;
        if (redirect_s) begin
            state_s = ST_RESTART;
            fpc_s   = target_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_FETCH;
                end
                ST_FETCH: begin
                    if (fpc_r[1:0] != 2'b00) begin
                        push_s     = 1'b1;
                        push_mis_s = 1'b1;
                        state_s    = ST_HALT;
                    end else if (cyc_r && iwbm_err_i) begin
                        push_s     = 1'b1;
                        push_err_s = 1'b1;
                        state_s    = ST_HALT;
                    end else if (cyc_r && iwbm_ack_i) begin
                        push_s     = 1'b1;
                        push_ins_s = iwbm_dat_i;
                        fpc_s      = fpc_r + 32'd4;
                        if (cnt_after_ack_s == CNT_FULL) begin
                            state_s = ST_WAIT;
                        end else begin
                            state_s = ST_FETCH;
                        end
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r < CNT_FULL) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_RESTART: begin
                    state_s = ST_FETCH;
                end
                ST_HALT: begin
                    state_s = ST_HALT;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Occupancy update and the registered bus request for the coming cycle.
    always_comb begin
        if (redirect_s) begin
            cnt_s = CNT_ZERO;
        end else if (push_s && !pop_s) begin
            cnt_s = cnt_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            cnt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
        cyc_s = (state_s == ST_FETCH) && (fpc_s[1:0] == 2'b00);
    end

    // Control state; reset drops the bus request immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            fpc_r   <= RESET_ADDR;
            cyc_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
        end else begin
            state_r <= state_s;
            fpc_r   <= fpc_s;
            cyc_r   <= cyc_s;
            cnt_r   <= cnt_s;
            if (redirect_s) begin
                wptr_r <= PTR_ZERO;
                rptr_r <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    wptr_r <= wptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rptr_r <= rptr_r + PTR_ONE;
                end
            end
        end
    end

    // Entry storage; contents are only ever read under a non-zero count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            pc_mem_r[wptr_r]  <= fpc_r;
            ins_mem_r[wptr_r] <= push_ins_s;
            err_mem_r[wptr_r] <= push_err_s;
            mis_mem_r[wptr_r] <= push_mis_s;
        end
    end

    // IF/ID pipeline register: flush, load the FIFO head, or insert a bubble when starved.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_pc_r     <= 32'h0000_0000;
            id_pc4_r    <= 32'h0000_0000;
            id_ins_r    <= NOP;
            id_exc_r    <= 1'b0;
            id_xcause_r <= 4'h0;
            id_bubble_r <= 1'b1;
        end else if (ifid_clear_i || redirect_s || (ifid_enable_i && (cnt_r == CNT_ZERO))) begin
            id_pc_r     <= 32'h0000_0000;
            id_pc4_r    <= 32'h0000_0000;
            id_ins_r    <= NOP;
            id_exc_r    <= 1'b0;
            id_xcause_r <= 4'h0;
            id_bubble_r <= 1'b1;
        end else if (pop_s) begin
            id_pc_r     <= pc_mem_r[rptr_r];
            id_pc4_r    <= pc_mem_r[rptr_r] + 32'd4;
            id_ins_r    <= ins_mem_r[rptr_r];
            id_exc_r    <= err_mem_r[rptr_r] | mis_mem_r[rptr_r];
            id_xcause_r <= err_mem_r[rptr_r] ? 4'h1 : 4'h0;
            id_bubble_r <= 1'b0;
        end
    end

    assign id_pc_o           = id_pc_r;
    assign id_pc4_o          = id_pc4_r;
    assign id_instruction_o  = id_ins_r;
    assign id_if_exception_o = id_exc_r;
    assign id_if_xcause_o    = id_xcause_r;
    assign id_bubble_o       = id_bubble_r;

    assign iwbm_addr_o = fpc_r;
    assign iwbm_dat_o  = 32'h0000_0000;
    assign iwbm_sel_o  = 4'hF;
    assign iwbm_we_o   = 1'b0;
    assign iwbm_cyc_o  = cyc_r;
    assign iwbm_stb_o  = cyc_r;
    assign if_ready_o  = (cnt_r != CNT_ZERO);

endmodule

// File: tb/tb_mirfak_fetch_unit.sv
// Bench for mirfak_fetch_unit: a queue-based fetch/ID model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mirfak_fetch_unit;

    localparam logic [31:0] RST_A = 32'h8000_0000;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_bj_i, pc_except_i, pc_xret_i;
    logic        pc_bj_sel_i, pc_except_sel_i, pc_xret_sel_i;
    logic [31:0] id_pc_o, id_pc4_o, id_instruction_o;
    logic        id_if_exception_o, id_bubble_o;
    logic [3:0]  id_if_xcause_o;
    logic [31:0] iwbm_addr_o, iwbm_dat_o, iwbm_dat_i;
    logic [3:0]  iwbm_sel_o;
    logic        iwbm_cyc_o, iwbm_stb_o, iwbm_we_o, iwbm_ack_i, iwbm_err_i;
    logic        ifid_enable_i, ifid_clear_i, if_ready_o;

    logic        ack_en, err_en;
    logic [31:0] err_addr;
    int          checks = 0;
    int          errors = 0;

    mirfak_fetch_unit #(.RESET_ADDR(RST_A), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pc_bj_i(pc_bj_i), .pc_except_i(pc_except_i), .pc_xret_i(pc_xret_i),
        .pc_bj_sel_i(pc_bj_sel_i), .pc_except_sel_i(pc_except_sel_i), .pc_xret_sel_i(pc_xret_sel_i),
        .id_pc_o(id_pc_o), .id_pc4_o(id_pc4_o), .id_instruction_o(id_instruction_o),
        .id_if_exception_o(id_if_exception_o), .id_if_xcause_o(id_if_xcause_o), .id_bubble_o(id_bubble_o),
        .iwbm_addr_o(iwbm_addr_o), .iwbm_dat_o(iwbm_dat_o), .iwbm_sel_o(iwbm_sel_o),
        .iwbm_cyc_o(iwbm_cyc_o), .iwbm_stb_o(iwbm_stb_o), .iwbm_we_o(iwbm_we_o),
        .iwbm_dat_i(iwbm_dat_i), .iwbm_ack_i(iwbm_ack_i), .iwbm_err_i(iwbm_err_i),
        .ifid_enable_i(ifid_enable_i), .ifid_clear_i(ifid_clear_i), .if_ready_o(if_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0013;
    endfunction

    // Memory slave: answers in the same cycle it sees a request.
    assign iwbm_err_i = iwbm_cyc_o & iwbm_stb_o & err_en & (iwbm_addr_o == err_addr);
    assign iwbm_ack_i = iwbm_cyc_o & iwbm_stb_o & ack_en & ~(err_en & (iwbm_addr_o == err_addr));
    assign iwbm_dat_i = instr_of(iwbm_addr_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
        logic        mis;
    } ent_t;

    ent_t        q[$];
    ent_t        m_e;
    logic [31:0] m_fpc, m_tgt;
    logic        m_halt, m_restart, m_redir, m_bus;
    int          m_mis_cnt;
    logic [31:0] e_pc, e_pc4, e_ins;
    logic        e_exc, e_bub;
    logic [3:0]  e_xc;

    function automatic void id_bubble_m();
        e_pc = 32'h0; e_pc4 = 32'h0; e_ins = NOP; e_exc = 1'b0; e_xc = 4'h0; e_bub = 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_fpc = RST_A; m_halt = 1'b0; m_restart = 1'b0; m_mis_cnt = 0;
            id_bubble_m();
        end else begin
            m_redir = pc_except_sel_i | pc_xret_sel_i | pc_bj_sel_i;
            m_tgt = pc_except_sel_i ? pc_except_i : (pc_xret_sel_i ? pc_xret_i : pc_bj_i);
            m_bus = iwbm_cyc_o & iwbm_stb_o;
            m_restart = 1'b0;
            if (m_redir) begin
                q.delete();
                id_bubble_m();
                m_fpc = m_tgt;
                m_halt = (m_tgt[1:0] != 2'b00);
                m_mis_cnt = m_halt ? 2 : 0;
                m_restart = 1'b1;
            end else begin
                if (ifid_clear_i) begin
                    id_bubble_m();
                end else if (ifid_enable_i) begin
                    if (q.size() > 0) begin
                        m_e = q.pop_front();
                        e_pc = m_e.pc; e_pc4 = m_e.pc + 32'd4; e_ins = m_e.ins;
                        e_exc = m_e.err | m_e.mis; e_xc = m_e.err ? 4'h1 : 4'h0; e_bub = 1'b0;
                    end else begin
                        id_bubble_m();
                    end
                end
                if (m_mis_cnt == 1) q.push_back('{pc: m_fpc, ins: NOP, err: 1'b0, mis: 1'b1});
                if (m_mis_cnt > 0) m_mis_cnt--;
                if (m_bus && iwbm_err_i) begin
                    q.push_back('{pc: m_fpc, ins: NOP, err: 1'b1, mis: 1'b0});
                    m_halt = 1'b1;
                end else if (m_bus && iwbm_ack_i) begin
                    q.push_back('{pc: m_fpc, ins: instr_of(m_fpc), err: 1'b0, mis: 1'b0});
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("if_ready", if_ready_o, q.size() != 0);
            chk("id_pc", id_pc_o, e_pc);
            chk("id_pc4", id_pc4_o, e_pc4);
            chk("id_instr", id_instruction_o, e_ins);
            chk("id_exc", id_if_exception_o, e_exc);
            chk("id_xcause", id_if_xcause_o, e_xc);
            chk("id_bubble", id_bubble_o, e_bub);
            chk("bus_const", {iwbm_we_o, iwbm_sel_o, iwbm_dat_o}, {1'b0, 4'hF, 32'h0});
            chk("stb_eq_cyc", iwbm_stb_o, iwbm_cyc_o);
            if (iwbm_cyc_o) chk("fetch_addr", iwbm_addr_o, m_fpc);
            if (m_halt || m_restart || q.size() >= DEPTH) chk("bus_idle", iwbm_cyc_o, 1'b0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic redirect(input logic s_exc, input logic s_xret, input logic s_bj,
                            input logic [31:0] t_exc, input logic [31:0] t_xret, input logic [31:0] t_bj);
        pc_except_i = t_exc; pc_xret_i = t_xret; pc_bj_i = t_bj;
        pc_except_sel_i = s_exc; pc_xret_sel_i = s_xret; pc_bj_sel_i = s_bj;
        step(1);
        pc_except_sel_i = 1'b0; pc_xret_sel_i = 1'b0; pc_bj_sel_i = 1'b0;
    endtask

    task automatic wait_bus(input int bound, input string name);
        int n = 0;
        while (!iwbm_cyc_o && n < bound) begin
            step(1);
            n++;
        end
        chk(name, iwbm_cyc_o, 1'b1);
    endtask

    task automatic wait_exc(input int bound, input string name);
        int n = 0;
        while (!id_if_exception_o && n < bound) begin
            step(1);
            n++;
        end
        chk(name, id_if_exception_o, 1'b1);
    endtask

    logic [31:0] addr_log [5];
    logic [31:0] pc_log   [5];
    logic        bub_log  [5];

    initial begin
        rst_n = 1'b0;
        pc_bj_i = 32'h0; pc_except_i = 32'h0; pc_xret_i = 32'h0;
        pc_bj_sel_i = 1'b0; pc_except_sel_i = 1'b0; pc_xret_sel_i = 1'b0;
        ifid_enable_i = 1'b0; ifid_clear_i = 1'b0;
        ack_en = 1'b0; err_en = 1'b0; err_addr = 32'h0;
        step(3);
        chk("rst_cyc", iwbm_cyc_o, 1'b0);
        chk("rst_ready", if_ready_o, 1'b0);
        chk("rst_bubble", id_bubble_o, 1'b1);
        chk("rst_instr", id_instruction_o, 32'h0000_0013);
        chk("rst_pc", id_pc_o, 32'h0);

        // Back-to-back fetch out of reset with ID consuming every cycle.
        ack_en = 1'b1; ifid_enable_i = 1'b1;
        rst_n = 1'b1;
        chk("release_idle", iwbm_cyc_o, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            addr_log[k] = iwbm_cyc_o ? iwbm_addr_o : 32'hDEAD_BEEF;
            pc_log[k]   = id_pc_o;
            bub_log[k]  = id_bubble_o;
        end
        chk("first_addr", addr_log[0], 32'h8000_0000);
        chk("second_addr", addr_log[1], 32'h8000_0004);
        chk("third_addr", addr_log[2], 32'h8000_0008);
        chk("id_first_pc", pc_log[2], 32'h8000_0000);
        chk("id_second_pc", pc_log[3], 32'h8000_0004);
        chk("id_third_pc", pc_log[4], 32'h8000_0008);
        chk("id_streaming", {bub_log[2], bub_log[3], bub_log[4]}, 3'b000);

        // Fill the FIFO with ID stalled, then release one slot.
        ifid_enable_i = 1'b0;
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0000);
        step(10);
        chk("full_stall_cyc", iwbm_cyc_o, 1'b0);
        chk("full_ready", if_ready_o, 1'b1);
        ifid_enable_i = 1'b1;
        step(1);
        ifid_enable_i = 1'b0;
        chk("full_pop_pc", id_pc_o, 32'h8000_0000);
        wait_bus(5, "refill_start");
        chk("refill_addr", iwbm_addr_o, 32'h8000_0010);

        // Branch redirect coinciding with an ack.
        ifid_enable_i = 1'b1;
        wait_bus(10, "pre_branch_bus");
        chk("ack_same_cycle", iwbm_ack_i, 1'b1);
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0100);
        chk("branch_flush_ready", if_ready_o, 1'b0);
        chk("branch_bubble", id_bubble_o, 1'b1);
        chk("branch_cyc_low", iwbm_cyc_o, 1'b0);
        wait_bus(5, "branch_bus");
        chk("branch_addr", iwbm_addr_o, 32'h8000_0100);

        // Target priority.
        redirect(1'b1, 1'b0, 1'b1, 32'h8000_0004, 32'h0, 32'h8000_0200);
        wait_bus(5, "prio_exc_bus");
        chk("prio_exc_over_bj", iwbm_addr_o, 32'h8000_0004);
        redirect(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0300, 32'h8000_0200);
        wait_bus(5, "prio_xret_bus");
        chk("prio_xret_over_bj", iwbm_addr_o, 32'h8000_0300);
        redirect(1'b1, 1'b1, 1'b1, 32'h8000_0040, 32'h8000_0300, 32'h8000_0200);
        wait_bus(5, "prio_all_bus");
        chk("prio_exc_over_all", iwbm_addr_o, 32'h8000_0040);

        // Bus error on the third fetch.
        ifid_enable_i = 1'b0;
        err_en = 1'b1; err_addr = 32'h8000_0008;
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0000);
        step(8);
        chk("err_halt_cyc", iwbm_cyc_o, 1'b0);
        ifid_enable_i = 1'b1;
        wait_exc(10, "err_exc_seen");
        chk("err_pc", id_pc_o, 32'h8000_0008);
        chk("err_xcause", id_if_xcause_o, 4'h1);
        chk("err_instr", id_instruction_o, 32'h0000_0013);
        step(5);
        chk("err_stays_idle", iwbm_cyc_o, 1'b0);
        err_en = 1'b0;

        // Misaligned redirect target.
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0002);
        wait_exc(10, "mis_exc_seen");
        chk("mis_pc", id_pc_o, 32'h8000_0002);
        chk("mis_xcause", id_if_xcause_o, 4'h0);
        chk("mis_no_bus", iwbm_cyc_o, 1'b0);

        // Fetch pointer wraps at the top of the address space.
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFC);
        wait_bus(5, "wrap_bus");
        chk("wrap_top", iwbm_addr_o, 32'hFFFF_FFFC);
        step(1);
        chk("wrap_zero", iwbm_addr_o, 32'h0000_0000);

        // ID flush keeps FIFO contents.
        ifid_enable_i = 1'b0;
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_1000);
        step(6);
        ifid_clear_i = 1'b1;
        step(1);
        ifid_clear_i = 1'b0;
        chk("clear_bubble", id_bubble_o, 1'b1);
        chk("clear_keeps_fifo", if_ready_o, 1'b1);
        ifid_enable_i = 1'b1;
        step(1);
        chk("after_clear_pc", id_pc_o, 32'h8000_1000);

        // Asynchronous reset in the middle of a bus cycle.
        wait_bus(10, "pre_reset_bus");
        rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", iwbm_cyc_o, 1'b0);
        chk("async_rst_ready", if_ready_o, 1'b0);
        chk("async_rst_bubble", id_bubble_o, 1'b1);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("rerst_cyc", iwbm_cyc_o, 1'b1);
        chk("rerst_addr", iwbm_addr_o, 32'h8000_0000);
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mirfak_fetch_unit.md
MIRFAK_FETCH_UNIT -- requirements
Module: mirfak_fetch_unit

Interface
REQ-001 Parameter RESET_ADDR, 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, 4, prefetch entries; power of two, >= 2.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 pc_bj_i, pc_except_i, pc_xret_i  input  32 each  redirect targets.
REQ-006 pc_bj_sel_i, pc_except_sel_i, pc_xret_sel_i  input  1 each  redirect requests.
REQ-007 id_pc_o, id_pc4_o, id_instruction_o  output  32 each  IF->ID pc, pc+4, instruction.
REQ-008 id_if_exception_o  output  1; id_if_xcause_o  output  4; id_bubble_o  output  1.
REQ-009 iwbm_addr_o  output  32; iwbm_dat_o  output  32; iwbm_sel_o  output  4; iwbm_cyc_o, iwbm_stb_o, iwbm_we_o  output  1 each.
REQ-010 iwbm_dat_i  input  32; iwbm_ack_i, iwbm_err_i  input  1 each.
REQ-011 ifid_enable_i, ifid_clear_i  input  1 each  ID advance / ID flush.
REQ-012 if_ready_o  output  1  FIFO non-empty.

Function
REQ-013 Redirect = any sel input high; target priority: except > xret > bj.
REQ-014 Fetch pointer fpc: on redirect fpc <= target; on accepted response fpc <= fpc+4 (mod 2^32); else holds.
REQ-015 FIFO entry = {pc, instruction, err, misaligned}; count width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
REQ-016 States: IDLE, FETCH, WAIT, RESTART, HALT; one state register.
REQ-017 IDLE: entered by reset; next cycle -> FETCH.
REQ-018 FETCH: cyc=stb=1, iwbm_addr_o=fpc; at most one outstanding request.
REQ-019 FETCH, fpc[1:0]!=0: no bus cycle (cyc=stb=0); push entry {fpc, NOP, misaligned=1} -> HALT.
REQ-020 FETCH, ack without redirect: push {fpc, iwbm_dat_i}; if post-cycle count==FIFO_DEPTH -> WAIT (cyc/stb low), else stay FETCH with cyc/stb held high at the new address (back-to-back).
REQ-021 FETCH, err without redirect: push {fpc, NOP, err=1}, cyc/stb low -> HALT.
REQ-022 WAIT: bus idle; when count < FIFO_DEPTH -> FETCH.
REQ-023 HALT: bus idle until redirect.
REQ-024 Redirect in any state: FIFO flushed (count=0), cyc/stb low next cycle, any same-cycle ack/err discarded (no push), -> RESTART; RESTART -> FETCH next cycle.
REQ-025 Push and pop in the same cycle: count unchanged; push when full never occurs.
REQ-026 if_ready_o = (count != 0); combinational from registered count.
REQ-027 IF/ID register: ifid_clear_i or redirect -> pc=0, pc4=0, instr=NOP (32'h0000_0013), exception=0, xcause=0, bubble=1.
REQ-028 Otherwise ifid_enable_i and if_ready_o: pop head; load pc, pc+4, instruction, exception=err|misaligned, xcause=1 (access fault) if err else 0 (misaligned); bubble=0.
REQ-029 ifid_enable_i with FIFO empty: load bubble (same values as REQ-027); no pop.
REQ-030 iwbm_dat_o=0, iwbm_sel_o=4'hF, iwbm_we_o=0 constant.

Reset
REQ-031 rst_ni low: immediately state=IDLE, fpc=RESET_ADDR, count=0, cyc=stb=0, IF/ID outputs as REQ-027, if_ready_o=0.
REQ-032 Reset mid-transaction: cyc/stb drop asynchronously; in-flight ack ignored.
REQ-033 First request at RESET_ADDR on the second rising edge after rst_ni deasserts.

Verification
REQ-034 Reset release, ack each cycle, ifid_enable_i=1 -> addresses 8000_0000, _0004, _0008 back-to-back; ID receives them in order, bubble=0.
REQ-035 FIFO_DEPTH=4, ifid_enable_i=0, ack always -> 4 pushes, cyc drops, state WAIT; one pop -> one new fetch at 8000_0010.
REQ-036 pc_bj_sel_i=1 (target 8000_0100) with ack same cycle -> response dropped, FIFO empty, bubble in ID, next request 8000_0100 after RESTART.
REQ-037 Simultaneous except_sel (8000_0004) and bj_sel (8000_0200) -> next fetch 8000_0004.
REQ-038 iwbm_err_i at 8000_0008 -> ID sees exception=1, xcause=1, instr NOP; no further bus cycle until redirect.
REQ-039 Redirect to 8000_0002 -> no bus cycle; ID sees exception=1, xcause=0, pc 8000_0002.
